// File: rtl/poly_summer.sv
`default_nettype none
// ============================================================================
// Module   : poly_summer
// Purpose  : Switch-driven signed polynomial evaluator using Horner's method,
//            one multiply-accumulate per clock. Coefficients and x are loaded
//            from switches with edge-detected buttons; the registered result
//            drives active-low 7-segment hex digits.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            swData          - signed operand from switches
//            GetA/GetX       - load next coefficient / load x (level buttons)
//            startAR         - start evaluation (level button)
//            readyAR, busy   - result valid / evaluation in progress
//            ovf             - sticky signed overflow of the last evaluation
//            coefPtr         - slot index the next GetA writes
//            result, displ   - registered result and its 7-segment image
// Revision : 1.0 - initial parametrised release
// ============================================================================
module poly_summer #(
    parameter int N_COEF   = 4,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int N_DIGITS = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           swData,
    input  logic                        GetA,
    input  logic                        GetX,
    input  logic                        startAR,
    output logic                        readyAR,
    output logic                        busy,
    output logic                        ovf,
    output logic [$clog2(N_COEF)-1:0]   coefPtr,
    output logic [ACC_W-1:0]            result,
    output logic [7*N_DIGITS-1:0]       displ
);

    localparam int c_PTR_W  = $clog2(N_COEF);
    // Wide enough that acc*x + coef never loses information.
    localparam int c_FULL_W = ACC_W + DATA_W + 1;

    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(N_COEF - 1);
    localparam logic [c_PTR_W-1:0] c_FIRST_IDX = c_PTR_W'(N_COEF - 2);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_STEP = 1'b1;

    logic [0:0]          r_state;
    logic                r_geta_q;
    logic                r_getx_q;
    logic                r_start_q;
    logic [DATA_W-1:0]   r_coef [N_COEF];
    logic [DATA_W-1:0]   r_x;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_PTR_W-1:0]  r_idx;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_result;
    logic                r_ready;
    logic                r_busy;
    logic                r_ovf;

    logic                w_geta_edge;
    logic                w_getx_edge;
    logic                w_start_edge;
    logic signed [c_FULL_W-1:0] w_acc_ext;
    logic signed [c_FULL_W-1:0] w_x_ext;
    logic signed [c_FULL_W-1:0] w_c_ext;
    logic signed [c_FULL_W-1:0] w_full;
    logic                w_fits;

    assign w_geta_edge  = GetA    & ~r_geta_q;
    assign w_getx_edge  = GetX    & ~r_getx_q;
    assign w_start_edge = startAR & ~r_start_q;

    // One Horner step: full-precision product plus the current coefficient.
    assign w_acc_ext = c_FULL_W'($signed(r_acc));
    assign w_x_ext   = c_FULL_W'($signed(r_x));
    assign w_c_ext   = c_FULL_W'($signed(r_coef[r_idx]));
    assign w_full    = w_acc_ext * w_x_ext + w_c_ext;
    // The step fits when sign-extending its low ACC_W bits reproduces it.
    assign w_fits    = (w_full == c_FULL_W'($signed(w_full[ACC_W-1:0])));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_geta_q  <= 1'b0;
            r_getx_q  <= 1'b0;
            r_start_q <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                r_coef[i] <= '0;
            end
            r_x       <= '0;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_geta_q  <= GetA;
            r_getx_q  <= GetX;
            r_start_q <= startAR;
            case (r_state)
                c_IDLE: begin
                    if (w_geta_edge) begin
                        r_coef[r_ptr] <= swData;
                        r_ptr         <= (r_ptr == c_LAST_PTR) ? '0 : r_ptr + 1'b1;
                        r_ready       <= 1'b0;
                    end
                    if (w_getx_edge) begin
                        r_x     <= swData;
                        r_ready <= 1'b0;
                    end
                    // Non-blocking reads here see the pre-load coefficient.
                    if (w_start_edge) begin
                        r_acc   <= ACC_W'($signed(r_coef[N_COEF-1]));
                        r_idx   <= c_FIRST_IDX;
                        r_ovf   <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= c_STEP;
                    end
                end
                c_STEP: begin
                    r_acc <= w_full[ACC_W-1:0];
                    r_ovf <= r_ovf | ~w_fits;
                    if (r_idx == '0) begin
                        r_result <= w_full[ACC_W-1:0];
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= c_IDLE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign readyAR = r_ready;
    assign busy    = r_busy;
    assign ovf     = r_ovf;
    assign coefPtr = r_ptr;
    assign result  = r_result;

    // Active-low gfedcba segment pattern for one hex nibble.
    function automatic logic [6:0] f_hex7(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
        assign displ[7*d +: 7] = f_hex7(r_result[4*d +: 4]);
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_summer.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_summer
// Purpose  : Self-checking bench for poly_summer (N_COEF=4, DATA_W=8,
//            ACC_W=16, N_DIGITS=4) against a behavioural polynomial model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_summer;

    localparam int N_COEF   = 4;
    localparam int DATA_W   = 8;
    localparam int ACC_W    = 16;
    localparam int N_DIGITS = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DATA_W-1:0]     swData = '0;
    logic                  GetA = 1'b0;
    logic                  GetX = 1'b0;
    logic                  startAR = 1'b0;
    logic                  readyAR;
    logic                  busy;
    logic                  ovf;
    logic [1:0]            coefPtr;
    logic [ACC_W-1:0]      result;
    logic [7*N_DIGITS-1:0] displ;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int               m_coef [N_COEF];
    int               m_x;
    int               m_ptr;
    logic [ACC_W-1:0] m_result;
    logic             m_ovf;

    poly_summer #(
        .N_COEF  (N_COEF),
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .N_DIGITS(N_DIGITS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .swData (swData),
        .GetA   (GetA),
        .GetX   (GetX),
        .startAR(startAR),
        .readyAR(readyAR),
        .busy   (busy),
        .ovf    (ovf),
        .coefPtr(coefPtr),
        .result (result),
        .displ  (displ)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int nib);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[nib];
    endfunction

    function automatic logic [7*N_DIGITS-1:0] displ_of(input logic [ACC_W-1:0] v);
        logic [7*N_DIGITS-1:0] d;
        d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            d[7*i +: 7] = seg_of(int'((v >> (4*i)) & 16'hF));
        end
        return d;
    endfunction

    function automatic int sx(input logic [DATA_W-1:0] v);
        return int'($signed(v));
    endfunction

    // Result = sum a_i * x^i modulo 2^ACC_W; overflow follows the Horner
    // partial sums, each of which must lie in the signed ACC_W range.
    task automatic model_eval();
        longint s, p, acc, full;
        logic [63:0] sw;
        s = 0;
        p = 1;
        for (int i = 0; i < N_COEF; i++) begin
            s += longint'(m_coef[i]) * p;
            p *= m_x;
        end
        sw = 64'(s);
        m_result = sw[ACC_W-1:0];
        m_ovf = 1'b0;
        acc = m_coef[N_COEF-1];
        for (int i = N_COEF-2; i >= 0; i--) begin
            full = acc * m_x + m_coef[i];
            if (full > 32767 || full < -32768) m_ovf = 1'b1;
            acc = full % 65536;
            if (acc > 32767) acc -= 65536;
            if (acc < -32768) acc += 65536;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_COEF; i++) m_coef[i] = 0;
        m_x = 0;
        m_ptr = 0;
        m_result = '0;
        m_ovf = 1'b0;
    endtask

    task automatic press_a(input logic [DATA_W-1:0] v);
        swData = v;
        GetA = 1'b1;
        tick();
        GetA = 1'b0;
        tick();
        m_coef[m_ptr] = sx(v);
        m_ptr = (m_ptr + 1) % N_COEF;
    endtask

    task automatic press_x(input logic [DATA_W-1:0] v);
        swData = v;
        GetX = 1'b1;
        tick();
        GetX = 1'b0;
        tick();
        m_x = sx(v);
    endtask

    task automatic press_both(input logic [DATA_W-1:0] v);
        swData = v;
        GetA = 1'b1;
        GetX = 1'b1;
        tick();
        GetA = 1'b0;
        GetX = 1'b0;
        tick();
        m_coef[m_ptr] = sx(v);
        m_ptr = (m_ptr + 1) % N_COEF;
        m_x = sx(v);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".result"}, 64'(result), 64'(m_result));
        check({tag, ".ovf"},    64'(ovf),    64'(m_ovf));
        check({tag, ".displ"},  64'(displ),  64'(displ_of(m_result)));
        check({tag, ".ptr"},    64'(coefPtr), 64'(m_ptr));
    endtask

    task automatic eval_and_check(input string tag);
        int n;
        model_eval();
        startAR = 1'b1;
        tick();
        startAR = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        check({tag, ".busy_cycles"}, 64'(n), 64'(N_COEF - 1));
        check({tag, ".ready"}, 64'(readyAR), 64'd1);
        check_outputs(tag);
    endtask

    initial begin
        int busy_cnt, rises, n;
        logic prev_ready;
        logic [DATA_W-1:0] v;

        model_reset();
        rst = 1'b1;
        tick();
        tick();
        check("reset.result", 64'(result), 64'd0);
        check("reset.ready",  64'(readyAR), 64'd0);
        check("reset.busy",   64'(busy), 64'd0);
        check("reset.ovf",    64'(ovf), 64'd0);
        check("reset.ptr",    64'(coefPtr), 64'd0);
        check("reset.displ",  64'(displ), 64'(displ_of('0)));
        rst = 1'b0;
        tick();

        // Basic evaluation: 1 + 2x + 3x^2 + 4x^3 at x = 2 -> 49.
        press_a(8'd1);
        press_a(8'd2);
        press_a(8'd3);
        press_a(8'd4);
        press_x(8'd2);
        check("basic.ptr_wrap", 64'(coefPtr), 64'd0);
        eval_and_check("basic");
        check("basic.value", 64'(result), 64'h31);
        check("basic.digits", 64'(displ), 64'({7'h40, 7'h40, 7'h30, 7'h79}));

        // Negative x.
        press_x(8'hFF);
        check("negx.ready_cleared", 64'(readyAR), 64'd0);
        eval_and_check("negx");
        check("negx.value", 64'(result), 64'hFFFE);

        // Overflow and its clearing on the next evaluation.
        for (int i = 0; i < N_COEF; i++) press_a(8'h7F);
        press_x(8'h7F);
        eval_and_check("ovf");
        check("ovf.value", 64'(result), 64'hFF00);
        check("ovf.flag",  64'(ovf), 64'd1);
        press_x(8'h00);
        eval_and_check("ovf_clear");
        check("ovf_clear.value", 64'(result), 64'h007F);

        // startAR held for 10 cycles gives one evaluation.
        press_x(8'h03);
        model_eval();
        startAR = 1'b1;
        busy_cnt = 0;
        rises = 0;
        prev_ready = readyAR;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (readyAR && !prev_ready) rises++;
            prev_ready = readyAR;
        end
        startAR = 1'b0;
        tick();
        check("hold_start.busy_cycles", 64'(busy_cnt), 64'(N_COEF - 1));
        check("hold_start.completions", 64'(rises), 64'd1);
        check_outputs("hold_start");

        // GetA held for 5 cycles advances the pointer once.
        swData = 8'h11;
        GetA = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        GetA = 1'b0;
        tick();
        m_coef[m_ptr] = sx(8'h11);
        m_ptr = (m_ptr + 1) % N_COEF;
        check("hold_geta.ptr", 64'(coefPtr), 64'(m_ptr));
        check("hold_geta.ready", 64'(readyAR), 64'd0);

        // GetA edge and a second startAR edge while busy are both ignored.
        model_eval();
        startAR = 1'b1;
        tick();
        startAR = 1'b0;
        swData = 8'h55;
        GetA = 1'b1;
        tick();
        GetA = 1'b0;
        startAR = 1'b1;
        tick();
        startAR = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        check("busy_ignore.ready", 64'(readyAR), 64'd1);
        check_outputs("busy_ignore");
        tick();
        tick();
        check("busy_ignore.no_restart", 64'(busy), 64'd0);
        eval_and_check("busy_ignore_recheck");

        // Randomised loads and evaluations.
        for (int it = 0; it < 25; it++) begin
            int na;
            na = $urandom_range(0, 5);
            for (int k = 0; k < na; k++) begin
                v = DATA_W'($urandom);
                if ($urandom_range(0, 3) == 0) v = (k[0]) ? 8'h80 : 8'h7F;
                if ($urandom_range(0, 4) == 0) press_both(v);
                else press_a(v);
            end
            if ($urandom_range(0, 1) == 1) press_x(DATA_W'($urandom));
            if (na > 0) check("rand.ready_cleared", 64'(readyAR), 64'd0);
            eval_and_check("rand");
        end

        // Reset in the second STEP cycle aborts the evaluation.
        startAR = 1'b1;
        tick();
        startAR = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        model_reset();
        check("midrst.busy",  64'(busy), 64'd0);
        check("midrst.ready", 64'(readyAR), 64'd0);
        check_outputs("midrst");
        rst = 1'b0;
        tick();
        eval_and_check("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/poly_summer.md
# poly_summer

Parametrised successor to the fixed four-term switch-driven polynomial summer. It evaluates a signed polynomial y = a0 + a1·x + … + a(N−1)·x^(N−1) with Horner's method, one multiply-accumulate per clock. Coefficients and x are entered from board switches with load buttons. The registered result drives a configurable number of 7-segment hex digits, and the block adds a sticky overflow flag, load-pointer visibility and button edge detection.

## Interface
- N_COEF, 4: number of coefficients, range 2..16.
- DATA_W, 8: switch, coefficient and x width, two's complement.
- ACC_W, 32: accumulator and result width, ≥ DATA_W.
- N_DIGITS, 6: hex digits displayed, range 1..ACC_W/4.

- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- swData  in  DATA_W  signed operand from switches.
- GetA  in  1  level button: load swData into the next coefficient slot.
- GetX  in  1  level button: load swData into x.
- startAR  in  1  level button: start evaluation.
- readyAR  out  1  result valid and current.
- busy  out  1  evaluation in progress.
- ovf  out  1  sticky signed overflow for the last evaluation.
- coefPtr  out  $clog2(N_COEF)  index of the next slot GetA writes.
- result  out  ACC_W  registered signed result.
- displ  out  7·N_DIGITS  digit d on bits [7d+6:7d], active-low segments gfedcba, showing result[4d+3:4d].

## Operation
- Edge detect: each button is registered once per clock. An action fires only on a clock edge where the button is 1 and was 0 at the previous edge. A held button produces exactly one action.
- GetA edge in IDLE:
  - coef[coefPtr] ← swData.
  - coefPtr increments and wraps from N_COEF−1 to 0.
  - readyAR ← 0.
- GetX edge in IDLE: x ← swData; readyAR ← 0.
- GetA and GetX edges while busy are ignored; no state changes.
- FSM has two states, IDLE and STEP.
  - IDLE + startAR edge:
    - acc ← sext(coef[N_COEF−1]).
    - idx ← N_COEF−2.
    - ovf ← 0; readyAR ← 0; busy ← 1.
    - Go to STEP.
  - STEP:
    - full = acc·sext(x) + sext(coef[idx]), computed at ACC_W+DATA_W+1 bits.
    - acc ← full[ACC_W−1:0].
    - ovf ← ovf | (full does not fit in ACC_W signed).
    - If idx == 0: result ← new acc, readyAR ← 1, busy ← 0, go to IDLE.
    - Otherwise idx ← idx−1.
  - A startAR edge in STEP is ignored.
- Results wrap modulo 2^ACC_W. ovf reports the wrap and does not saturate.
- readyAR stays high in IDLE until the next GetA, GetX or startAR edge.
- result holds its value until the next completion. It is not cleared by loads.
- displ is combinational from result via the hex-to-7-segment map, 0 = 7'h40 … F = 7'h0E.

## Timing
- Reset values:
  - result = 0, readyAR = 0, busy = 0, ovf = 0, coefPtr = 0.
  - All coefficients and x = 0; FSM in IDLE.
  - Every displ digit = 7'h40.
  - Edge-detect history = 0: a button held high through reset fires one action after reset release.
- Latency: a startAR edge accepted at clock edge E0 raises readyAR, and updates result, at edge E0+N_COEF−1. busy is high for N_COEF−1 cycles.
- A load action takes effect at its detection edge and is visible one cycle later.
- Simultaneous GetA and GetX edges in IDLE are both performed.
- startAR together with GetA or GetX in IDLE: the loads are performed, and evaluation starts using the pre-load values.
- rst mid-evaluation aborts at the next edge with all reset values.
- No throughput overlap: a new start is accepted only in IDLE.

## Test plan
- Reset check: assert rst 2 cycles → result = 0, readyAR = busy = ovf = 0, coefPtr = 0, every digit 7'h40.
- Basic evaluation (defaults):
  - Stimulus: GetA with swData 1, 2, 3, 4 (a0..a3), GetX with 2, then startAR.
  - Expected: busy for 3 cycles; readyAR at E0+3; result = 0x00000031; displ digit0 = 7'h79 ('1'), digit1 = 7'h30 ('3'), other digits 7'h40; ovf = 0; coefPtr = 0 after the 4 loads.
- Negative x: same coefficients, x = 0xFF (−1) → result = 0xFFFFFFFE, ovf = 0.
- Overflow (ACC_W = 16): all coefficients 0x7F, x = 0x7F → result = 0xFF00, ovf = 1. A following evaluation with x = 0 → result = 0x007F, ovf = 0.
- Button discipline:
  - Hold startAR for 10 cycles → exactly one evaluation.
  - Hold GetA for 5 cycles → coefPtr advances by 1.
  - GetA edge during busy → coefficients and coefPtr unchanged.
  - Second startAR edge during busy → ignored.
- Reset mid-operation: assert rst in the 2nd STEP cycle → the next cycle shows busy = 0, readyAR = 0, result = 0, coefPtr = 0, FSM in IDLE.
